// File: rtl/ucsbece154_refill_ctrl.sv
// Instruction-cache line refill controller.
// Accepts a miss, issues a block-aligned burst read, collects BLOCK_WORDS
// words, forwards the critical (missed) word early, and publishes the
// completed line. A request that sees no data within TIMEOUT cycles is abandoned.
module ucsbece154_refill_ctrl #(
  parameter int BLOCK_WORDS = 4,
  parameter int TIMEOUT     = 255
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      MissReq,
  input  logic [31:0]               MissAddr,
  output logic                      ReadRequest,
  output logic [31:0]               ReadAddress,
  input  logic [31:0]               DataIn,
  input  logic                      DataReady,
  output logic                      Busy,
  output logic                      CritWordValid,
  output logic [31:0]               CritWord,
  output logic                      RefillDone,
  output logic [32*BLOCK_WORDS-1:0] RefillLine,
  output logic [31:0]               RefillAddr,
  output logic                      Timeout
);

  localparam int CW = $clog2(BLOCK_WORDS);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST_SLOT = CW'(BLOCK_WORDS - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST, S_DONE} state_t;

  state_t                    state_q, state_d;
  logic [CW-1:0]             word_cnt_q, word_cnt_d;
  logic [CW-1:0]             offset_q, offset_d;
  logic [WW-1:0]             wait_cnt_q, wait_cnt_d;
  logic                      read_req_q, read_req_d;
  logic [31:0]               read_addr_q, read_addr_d;
  logic                      crit_valid_q, crit_valid_d;
  logic [31:0]               crit_word_q, crit_word_d;
  logic                      done_q, done_d;
  logic                      timeout_q, timeout_d;
  logic [31:0]               line_q [BLOCK_WORDS];
  logic [31:0]               line_d [BLOCK_WORDS];
  logic [32*BLOCK_WORDS-1:0] refill_line_q, refill_line_d;
  logic [31:0]               refill_addr_q, refill_addr_d;
  logic [32*BLOCK_WORDS-1:0] line_packed;

  // Byte-offset bits within a word carry no information for a word-wide refill.
  logic unused_byte_bits;
  assign unused_byte_bits = &{1'b0, MissAddr[1:0]};

  // Flatten the word buffer so a finished line can be published in one step.
  for (genvar gi = 0; gi < BLOCK_WORDS; gi++) begin : g_pack
    assign line_packed[32*gi +: 32] = line_q[gi];
  end

  // Next-state and datapath decisions; pulses default low, everything else holds.
  always_comb begin
    state_d       = state_q;
    word_cnt_d    = word_cnt_q;
    offset_d      = offset_q;
    wait_cnt_d    = wait_cnt_q;
    read_req_d    = read_req_q;
    read_addr_d   = read_addr_q;
    crit_valid_d  = 1'b0;
    crit_word_d   = crit_word_q;
    done_d        = 1'b0;
    timeout_d     = 1'b0;
    line_d        = line_q;
    refill_line_d = refill_line_q;
    refill_addr_d = refill_addr_q;

    case (state_q)
      S_IDLE: begin
        if (MissReq) begin
          state_d     = S_WAIT;
          read_req_d  = 1'b1;
          read_addr_d = {MissAddr[31:CW+2], {(CW+2){1'b0}}};
          offset_d    = MissAddr[CW+1:2];
          word_cnt_d  = '0;
          wait_cnt_d  = '0;
        end
      end
      S_WAIT, S_BURST: begin
        if (DataReady) begin
          line_d[word_cnt_q] = DataIn;
          if (word_cnt_q == offset_q) begin
            crit_valid_d = 1'b1;
            crit_word_d  = DataIn;
          end
          if (word_cnt_q == LAST_SLOT) begin
            // Final word: earlier slots are already in line_q, so splice this one in.
            state_d       = S_DONE;
            read_req_d    = 1'b0;
            done_d        = 1'b1;
            refill_addr_d = read_addr_q;
            refill_line_d = line_packed;
            refill_line_d[32*(BLOCK_WORDS-1) +: 32] = DataIn;
          end else begin
            word_cnt_d = word_cnt_q + 1'b1;
            state_d    = S_BURST;
          end
        end else if (state_q == S_WAIT) begin
          // Only the initial latency is bounded; stalls mid-burst wait indefinitely.
          if (wait_cnt_q >= WW'(TIMEOUT - 1)) begin
            wait_cnt_d = WW'(TIMEOUT);
            state_d    = S_IDLE;
            read_req_d = 1'b0;
            timeout_d  = 1'b1;
          end else begin
            wait_cnt_d = wait_cnt_q + 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      word_cnt_q    <= '0;
      offset_q      <= '0;
      wait_cnt_q    <= '0;
      read_req_q    <= 1'b0;
      read_addr_q   <= '0;
      crit_valid_q  <= 1'b0;
      crit_word_q   <= '0;
      done_q        <= 1'b0;
      timeout_q     <= 1'b0;
      refill_line_q <= '0;
      refill_addr_q <= '0;
      for (int i = 0; i < BLOCK_WORDS; i++) begin
        line_q[i] <= '0;
      end
    end else begin
      state_q       <= state_d;
      word_cnt_q    <= word_cnt_d;
      offset_q      <= offset_d;
      wait_cnt_q    <= wait_cnt_d;
      read_req_q    <= read_req_d;
      read_addr_q   <= read_addr_d;
      crit_valid_q  <= crit_valid_d;
      crit_word_q   <= crit_word_d;
      done_q        <= done_d;
      timeout_q     <= timeout_d;
      refill_line_q <= refill_line_d;
      refill_addr_q <= refill_addr_d;
      line_q        <= line_d;
    end
  end

  assign ReadRequest   = read_req_q;
  assign ReadAddress   = read_addr_q;
  assign Busy          = (state_q != S_IDLE);
  assign CritWordValid = crit_valid_q;
  assign CritWord      = crit_word_q;
  assign RefillDone    = done_q;
  assign RefillLine    = refill_line_q;
  assign RefillAddr    = refill_addr_q;
  assign Timeout       = timeout_q;

endmodule

// File: tb/tb_ucsbece154_refill_ctrl.sv
// Self-checking bench for the refill controller: directed vector table,
// a reset-mid-burst sequence, and randomized refills against a
// transaction-level model of capture/critical-word/done/timeout timing.
module tb_ucsbece154_refill_ctrl;
  localparam int BW = 4;
  localparam int TO = 10;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         MissReq = 1'b0;
  logic [31:0]  MissAddr = '0;
  logic [31:0]  DataIn = '0;
  logic         DataReady = 1'b0;
  logic         ReadRequest, Busy, CritWordValid, RefillDone, Timeout;
  logic [31:0]  ReadAddress, CritWord, RefillAddr;
  logic [127:0] RefillLine;

  ucsbece154_refill_ctrl #(.BLOCK_WORDS(BW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .MissReq(MissReq), .MissAddr(MissAddr),
    .ReadRequest(ReadRequest), .ReadAddress(ReadAddress), .DataIn(DataIn),
    .DataReady(DataReady), .Busy(Busy), .CritWordValid(CritWordValid),
    .CritWord(CritWord), .RefillDone(RefillDone), .RefillLine(RefillLine),
    .RefillAddr(RefillAddr), .Timeout(Timeout)
  );

  always #5 clk = ~clk;

  logic [31:0]  mem [256];
  int           n_pass = 0;
  int           n_total = 0;
  logic [31:0]  prev_crit = '0;
  logic [127:0] prev_line = '0;
  logic [31:0]  prev_raddr = '0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] pat;     // bit t = DataReady in cycle t after acceptance
    int          exp_done;
    int          exp_crit;
    int          exp_to;
  } vec_t;

  function automatic logic [31:0] mem_at(input logic [31:0] a);
    return mem[a[9:2]];
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      MissReq = 1'b0; MissAddr = $urandom;
      DataReady = 1'($urandom_range(0, 1)); DataIn = $urandom;
      step();
      chk("idle Busy", Busy, 0);
      chk("idle ReadRequest", ReadRequest, 0);
      chk("idle RefillDone", RefillDone, 0);
      chk("idle CritWordValid", CritWordValid, 0);
      chk("idle Timeout", Timeout, 0);
      chk("idle CritWord", CritWord, prev_crit);
      chk("idle RefillLine", RefillLine, prev_line);
      chk("idle RefillAddr", RefillAddr, prev_raddr);
    end
  endtask

  // One refill transaction; expected timing derived from the DataReady pattern.
  task automatic run_refill(input logic [31:0] addr, input logic [31:0] pat,
                            input bit use_exp, input int exp_done, input int exp_crit,
                            input int exp_to);
    logic [31:0]  blk, crit_w;
    logic [127:0] new_line;
    int off, caps, done_t, crit_t, to_t, end_t, obs_done, obs_crit, obs_to, dcap;
    bit dr, active, exp_busy, exp_rr;
    blk = addr & ~(32'(BW * 4) - 32'd1);
    off = int'((addr >> 2) % 32'(BW));
    caps = 0; done_t = -1; crit_t = -1; to_t = -1;
    for (int t = 0; t < 200; t++) begin
      if (caps == 0 && t == TO) begin to_t = t; break; end
      dr = (t < 32) ? pat[t] : 1'b1;
      if (dr) begin
        if (caps == off) crit_t = t + 1;
        caps++;
        if (caps == BW) begin done_t = t + 1; break; end
      end
    end
    for (int k = 0; k < BW; k++) new_line[32*k +: 32] = mem_at(blk + 32'(4 * k));
    crit_w = mem_at(blk + 32'(4 * off));
    end_t = (done_t >= 0) ? done_t + 1 : to_t;

    MissReq = 1'b1; MissAddr = addr | 32'($urandom_range(0, 3));
    DataReady = 1'($urandom_range(0, 1)); DataIn = $urandom;
    step();
    obs_done = -1; obs_crit = -1; obs_to = -1; dcap = 0;
    for (int t = 0; t <= end_t; t++) begin
      exp_busy = (done_t >= 0) ? (t <= done_t) : (t < to_t);
      exp_rr   = (done_t >= 0) ? (t < done_t) : (t < to_t);
      chk("Busy", Busy, exp_busy);
      chk("ReadRequest", ReadRequest, exp_rr);
      if (exp_rr) chk("ReadAddress", ReadAddress, blk);
      chk("RefillDone", RefillDone, (t == done_t));
      chk("Timeout", Timeout, (t == to_t));
      chk("CritWordValid", CritWordValid, (t == crit_t));
      chk("CritWord", CritWord, (crit_t >= 0 && t >= crit_t) ? crit_w : prev_crit);
      chk("RefillLine", RefillLine, (done_t >= 0 && t >= done_t) ? new_line : prev_line);
      chk("RefillAddr", RefillAddr, (done_t >= 0 && t >= done_t) ? blk : prev_raddr);
      if (RefillDone && obs_done < 0) obs_done = t;
      if (CritWordValid && obs_crit < 0) obs_crit = t;
      if (Timeout && obs_to < 0) obs_to = t;
      dr = (t < 32) ? pat[t] : 1'b1;
      active = exp_rr;
      if (active && dr) begin
        DataReady = 1'b1; DataIn = mem_at(blk + 32'(4 * dcap)); dcap++;
      end else begin
        DataReady = active ? 1'b0 : 1'($urandom_range(0, 1)); DataIn = $urandom;
      end
      MissReq = (t >= ((done_t >= 0) ? done_t : to_t)) ? 1'b0 : 1'b1;
      MissAddr = $urandom;
      step();
    end
    if (done_t >= 0) begin prev_line = new_line; prev_raddr = blk; end
    if (crit_t >= 0) prev_crit = crit_w;
    if (use_exp) begin
      chk("done cycle", obs_done, exp_done);
      chk("crit cycle", obs_crit, exp_crit);
      chk("timeout cycle", obs_to, exp_to);
    end
    $display("refill addr=%h pat=%h done_t=%0d crit_t=%0d to_t=%0d", addr, pat, done_t, crit_t, to_t);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    logic [31:0] a, p;
    vecs[0] = '{32'h0001_0008, 32'h0000_FFF8, 7, 6, -1};
    vecs[1] = '{32'h0001_0004, 32'h0000_0059, 7, 4, -1};
    vecs[2] = '{32'h0001_001C, 32'hFFFF_FFFF, 4, 4, -1};
    vecs[3] = '{32'h0001_0020, 32'h0000_0000, -1, -1, 10};
    vecs[4] = '{32'h0001_0030, 32'h0000_5555, 7, 1, -1};
    vecs[5] = '{32'h0001_0044, 32'hFFFF_FE00, 13, 11, -1};
    for (int i = 0; i < 256; i++) mem[i] = $urandom;

    // Reset with random activity on the inputs.
    for (int i = 0; i < 3; i++) begin
      MissReq = 1'($urandom_range(0, 1)); MissAddr = $urandom;
      DataReady = 1'($urandom_range(0, 1)); DataIn = $urandom;
      step();
    end
    chk("reset ReadRequest", ReadRequest, 0);
    chk("reset ReadAddress", ReadAddress, 0);
    chk("reset Busy", Busy, 0);
    chk("reset CritWordValid", CritWordValid, 0);
    chk("reset CritWord", CritWord, 0);
    chk("reset RefillDone", RefillDone, 0);
    chk("reset Timeout", Timeout, 0);
    chk("reset RefillLine", RefillLine, 0);
    chk("reset RefillAddr", RefillAddr, 0);
    reset = 1'b1;
    idle_cycles(2);

    for (int i = 0; i < 6; i++) begin
      run_refill(vecs[i].addr, vecs[i].pat, 1'b1, vecs[i].exp_done, vecs[i].exp_crit, vecs[i].exp_to);
      idle_cycles(2);
    end

    // Reset after two captures aborts the refill.
    MissReq = 1'b1; MissAddr = 32'h0001_000C; DataReady = 1'b0;
    step();
    DataReady = 1'b1; DataIn = mem_at(32'h0001_0000); step();
    DataIn = mem_at(32'h0001_0004); step();
    chk("midburst Busy", Busy, 1);
    reset = 1'b0; DataIn = mem_at(32'h0001_0008);
    step();
    chk("abort ReadRequest", ReadRequest, 0);
    chk("abort ReadAddress", ReadAddress, 0);
    chk("abort Busy", Busy, 0);
    chk("abort CritWordValid", CritWordValid, 0);
    chk("abort CritWord", CritWord, 0);
    chk("abort RefillDone", RefillDone, 0);
    chk("abort Timeout", Timeout, 0);
    chk("abort RefillLine", RefillLine, 0);
    chk("abort RefillAddr", RefillAddr, 0);
    reset = 1'b1;
    prev_crit = '0; prev_line = '0; prev_raddr = '0;
    idle_cycles(3);
    run_refill(32'h0001_0010, 32'hFFFF_FFFF, 1'b1, 4, 1, -1);
    idle_cycles(1);

    // Randomized refills.
    for (int i = 0; i < 30; i++) begin
      a = 32'h0001_0000 | (32'($urandom_range(0, 255)) << 2);
      p = (i % 3 == 0) ? ($urandom & $urandom) : $urandom;
      run_refill(a, p, 1'b0, 0, 0, 0);
      idle_cycles(1 + (i % 2));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/ucsbece154_refill_ctrl.md
UCSBECE154_REFILL_CTRL -- requirements
Module: ucsbece154_refill_ctrl

Interface
REQ-001 Parameter BLOCK_WORDS, default 4: words per line and per burst; power of two, at least 2; must match the instruction memory burst length.
REQ-002 Parameter TIMEOUT, default 255: maximum WAIT-state cycles before the request is abandoned.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-low reset (0 = reset, sampled on the clk rising edge).
REQ-005 MissReq  input  1  cache miss request, level; cache holds it until RefillDone or Timeout.
REQ-006 MissAddr  input  32  miss byte address; sampled only on acceptance.
REQ-007 ReadRequest  output  1  memory-bus request; registered.
REQ-008 ReadAddress  output  32  block-aligned bus address; registered.
REQ-009 DataIn  input  32  burst word from memory.
REQ-010 DataReady  input  1  DataIn valid this cycle.
REQ-011 Busy  output  1  high in every state except IDLE.
REQ-012 CritWordValid  output  1  one-cycle pulse: the missed word is available.
REQ-013 CritWord  output  32  the missed word; held until the next capture.
REQ-014 RefillDone  output  1  one-cycle pulse: the full line is valid.
REQ-015 RefillLine  output  32*BLOCK_WORDS  word k in bits [32k+31:32k].
REQ-016 RefillAddr  output  32  block-aligned address of RefillLine.
REQ-017 Timeout  output  1  one-cycle pulse: the request was abandoned.

Function
REQ-018 FSM states: IDLE, WAIT, BURST, DONE.
REQ-019 IDLE and MissReq=1: latch the block address (MissAddr with the low log2(BLOCK_WORDS)+2 bits cleared) and the word offset; clear the word counter and wait counter; go to WAIT; assert ReadRequest with ReadAddress = block address from the next cycle.
REQ-020 MissReq is ignored outside IDLE; MissAddr bits [1:0] are ignored.
REQ-021 In WAIT and BURST: ReadRequest=1 and ReadAddress is held constant.
REQ-022 Word capture: in WAIT or BURST with DataReady=1, store DataIn into line slot [counter] and increment the counter.
REQ-023 The first capture moves WAIT to BURST.
REQ-024 DataReady=0 in BURST is a stall: no capture, no counter change, state held.
REQ-025 Each WAIT cycle without DataReady increments the wait counter; on reaching TIMEOUT: go to IDLE, drop ReadRequest the next cycle, pulse Timeout, leave RefillLine/RefillAddr unchanged.
REQ-026 Capture of the final slot (counter = BLOCK_WORDS-1): go to DONE.
REQ-027 DONE lasts one cycle: RefillDone=1, ReadRequest=0, RefillLine and RefillAddr updated and valid; then IDLE.
REQ-028 Capture of the slot equal to the latched offset: the next cycle, CritWordValid=1 for one cycle with CritWord = that DataIn; the pulse occurs at most once per refill.
REQ-029 If the offset is the last slot, CritWordValid and RefillDone assert in the same cycle.
REQ-030 DataReady while in IDLE or DONE is ignored; no storage or output changes.
REQ-031 The word counter is log2(BLOCK_WORDS) bits and never wraps within a refill; the wait counter saturates at TIMEOUT.
REQ-032 RefillLine and RefillAddr hold their last completed values until the next RefillDone.

Reset
REQ-033 reset=0 at a clock edge: state IDLE; ReadRequest=0; ReadAddress=0; Busy=0; CritWordValid=0; CritWord=0; RefillDone=0; Timeout=0; RefillLine=0; RefillAddr=0; counters=0.
REQ-034 Reset mid-refill aborts the refill with no RefillDone or CritWordValid; the first MissReq after reset release is accepted normally.

Verification
REQ-035 Basic miss: MissAddr=0x00010008 and memory model with T0 delay 40 -> ReadAddress=0x00010000 held for the whole request; CritWordValid with word 2; RefillDone the cycle after the 4th word; RefillLine slots 0..3 equal mem[0x10000..0x1000C].
REQ-036 Stalled burst: DataReady pattern 1,0,0,1,1,0,1 -> exactly 4 captures in order; RefillDone 1 cycle after the last 1; ReadRequest=0 in that same cycle.
REQ-037 Last-word critical: MissAddr=0x0001001C -> CritWordValid and RefillDone coincide; CritWord=mem[0x1001C].
REQ-038 Timeout: TIMEOUT=10 and DataReady never asserted -> Timeout pulse after 10 WAIT cycles; ReadRequest falls; Busy=0; RefillAddr unchanged.
REQ-039 Reset mid-burst: reset=0 after 2 captures -> all outputs at reset values next cycle; no RefillDone; new miss to 0x00010010 then completes correctly.
REQ-040 Spurious/ignored inputs: DataReady pulses in IDLE plus a MissReq change while Busy -> no capture; ReadAddress stays at the original block.
